// File: rtl/dma_io_channel.sv
// DMA receive channel: wins the bus from the CPU, acknowledges a streaming I/O
// device and writes each captured word to consecutive memory addresses.
module dma_io_channel #(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [CNT_W-1:0]  max_words_i,
    input  logic              gpio_req_i,
    input  logic [31:0]       io_data_i,
    output logic              ack_o,
    output logic              io_write_o,
    output logic              bus_req_o,
    input  logic              bus_grant_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [CNT_W-1:0]  word_count_o,
    output logic              done_o,
    output logic              abort_o
);

    typedef enum logic [2:0] {IDLE, BUSREQ, ACK, XFER, DONE} state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } mem_wr_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort_q, abort_d;
    mem_wr_t           wr_q, wr_d;
    logic              ack_q, bus_req_q, io_write_q, done_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        wr_d    = wr_q;
        wr_d.we = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && gpio_req_i && (max_words_i != '0)) begin
                    base_d  = start_addr_i;
                    max_d   = max_words_i;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = BUSREQ;
                end
            end
            BUSREQ: begin
                // A device that gives up before the grant ends the burst unacknowledged.
                if (!gpio_req_i)      state_d = DONE;
                else if (bus_grant_i) state_d = ACK;
            end
            ACK:  state_d = XFER;
            XFER: begin
                if (!bus_grant_i) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (!gpio_req_i) begin
                    state_d = DONE;
                end else begin
                    wr_d.we   = 1'b1;
                    wr_d.addr = base_q + ADDR_W'(cnt_q);
                    wr_d.data = io_data_i;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_d == max_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they flop with it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            wr_q       <= '0;
            ack_q      <= 1'b0;
            bus_req_q  <= 1'b0;
            io_write_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            max_q      <= max_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            wr_q       <= wr_d;
            ack_q      <= (state_d == ACK) || (state_d == XFER);
            bus_req_q  <= (state_d == BUSREQ) || (state_d == ACK) || (state_d == XFER);
            io_write_q <= !((state_d == ACK) || (state_d == XFER));
            done_q     <= (state_d == DONE);
        end
    end

    assign ack_o        = ack_q;
    assign bus_req_o    = bus_req_q;
    assign io_write_o   = io_write_q;
    assign done_o       = done_q;
    assign abort_o      = abort_q;
    assign word_count_o = cnt_q;
    assign mem_we_o     = wr_q.we;
    assign mem_addr_o   = wr_q.addr;
    assign mem_wdata_o  = wr_q.data;

endmodule

// File: tb/tb_dma_io_channel.sv
// Bench for dma_io_channel: device model plus write scoreboard.
module tb_dma_io_channel;
    localparam int AW = 13;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n, enable, gpio_req, bus_grant;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] max_words;
    logic [31:0]   io_data;
    logic          ack, io_write, bus_req, mem_we, done, abort;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    dma_io_channel #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .start_addr_i(start_addr),
        .max_words_i(max_words), .gpio_req_i(gpio_req), .io_data_i(io_data),
        .ack_o(ack), .io_write_o(io_write), .bus_req_o(bus_req), .bus_grant_i(bus_grant),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .word_count_o(word_count), .done_o(done), .abort_o(abort)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct { logic [AW-1:0] addr; logic [31:0] data; } exp_t;
    exp_t sb[$];

    task automatic push_exp(input logic [AW-1:0] start, input logic [31:0] base, input int n);
        logic [AW-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{a, base + 32'(i)});
            a = a + 1'b1;
        end
    endtask

    // Device: presents its next word and advances once a capture edge passes
    // (ack held for at least one full cycle, request and grant both high).
    int          ptr = 0, dev_lo = 0, dev_end = 0;
    logic        dev_on = 1'b0;
    logic [31:0] dev_base = '0;
    logic        ack_d1 = 1'b0;

    always @(posedge clk) begin
        ack_d1 <= ack;
        if (ack && ack_d1 && gpio_req && bus_grant) ptr <= ptr + 1;
    end
    assign gpio_req = dev_on && (ptr < dev_end);
    assign io_data  = dev_base + 32'(ptr - dev_lo);

    task automatic load_dev(input logic [31:0] base, input int n);
        dev_lo   = ptr;
        dev_end  = ptr + n;
        dev_base = base;
        dev_on   = 1'b1;
    endtask

    int wr_cnt = 0;
    bit seen_ack = 0, seen_br = 0;

    always @(negedge clk) begin
        if (ack) seen_ack = 1;
        if (bus_req) seen_br = 1;
        if (mem_we) begin
            exp_t e;
            wr_cnt++;
            check("wr_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic wait_writes(input string tag, input int k);
        int w0 = wr_cnt;
        int n  = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (wr_cnt < w0 + k && n < 200);
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        rst_n = 0; enable = 0; bus_grant = 0; start_addr = '0; max_words = '0;
        #12;
        check("rst_ack", 32'(ack), 0);
        check("rst_io_write", 32'(io_write), 1);
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_misc", {word_count, done, abort}, 0);
        tick();
        rst_n = 1;

        // Basic burst: 5 words, device then runs dry.
        tick();
        bus_grant = 1; start_addr = 13'h100; max_words = 32; enable = 1;
        push_exp(13'h100, 32'hA0, 5);
        load_dev(32'hA0, 5);
        @(posedge clk); #1;
        check("req_latency", 32'(bus_req), 1);
        wait_done("basic");
        check("basic_wc", 32'(word_count), 5);
        check("basic_abort", 32'(abort), 0);
        tick();
        check("basic_sb", 32'(sb.size()), 0);
        check("basic_done_pulse", 32'(done), 0);

        // Terminal count with a device that keeps requesting.
        start_addr = 13'h200; max_words = 3;
        push_exp(13'h200, 32'hB0, 3);
        load_dev(32'hB0, 8);
        wait_done("term");
        check("term_wc", 32'(word_count), 3);
        check("term_ack_drop", 32'(ack), 0);
        bus_grant = 0;
        tick();
        check("term_idle_gap", 32'(bus_req), 0);
        tick();
        check("term_rearm", 32'(bus_req), 1);
        dev_on = 0;
        wait_done("term_rearm");
        check("term_rearm_wc", 32'(word_count), 0);
        tick();
        check("term_sb", 32'(sb.size()), 0);

        // Grant withheld 4 cycles, then lost after 2 captures.
        start_addr = 13'h300; max_words = 32; seen_ack = 0;
        push_exp(13'h300, 32'hC0, 2);
        load_dev(32'hC0, 6);
        repeat (4) tick();
        check("gl_ack_before_grant", 32'(seen_ack), 0);
        check("gl_bus_req_held", 32'(bus_req), 1);
        bus_grant = 1;
        wait_writes("gl", 2);
        bus_grant = 0;
        wait_done("gl");
        check("gl_abort", 32'(abort), 1);
        check("gl_wc", 32'(word_count), 2);
        push_exp(13'h300, 32'hC2, 4);
        bus_grant = 1;
        tick();
        tick();
        check("gl_abort_clr", 32'(abort), 0);
        wait_done("gl_next");
        check("gl_next_wc", 32'(word_count), 4);
        tick();
        check("gl_sb", 32'(sb.size()), 0);

        // Address wrap at top of memory.
        start_addr = 13'd8190; max_words = 10;
        push_exp(13'd8190, 32'hD0, 4);
        load_dev(32'hD0, 4);
        wait_done("wrap");
        check("wrap_wc", 32'(word_count), 4);
        tick();
        check("wrap_sb", 32'(sb.size()), 0);

        // Reset in the middle of a transfer.
        start_addr = 13'h400; max_words = 32;
        push_exp(13'h400, 32'hE0, 2);
        load_dev(32'hE0, 8);
        wait_writes("mrst", 2);
        rst_n = 0;
        #1;
        check("mrst_ack", 32'(ack), 0);
        check("mrst_bus_req", 32'(bus_req), 0);
        check("mrst_mem_we", 32'(mem_we), 0);
        check("mrst_wc", 32'(word_count), 0);
        check("mrst_io_write", 32'(io_write), 1);
        dev_on = 0; enable = 0;
        tick();
        rst_n = 1;
        seen_br = 0;
        repeat (3) tick();
        check("mrst_idle", 32'(seen_br), 0);
        check("mrst_sb", 32'(sb.size()), 0);

        // Guards: zero max_words, disabled channel, request dropped in BUSREQ.
        enable = 1; max_words = 0; seen_br = 0;
        load_dev(32'hF0, 4);
        repeat (8) tick();
        check("guard_max0", 32'(seen_br), 0);
        enable = 0; max_words = 5;
        repeat (8) tick();
        check("guard_enable", 32'(seen_br), 0);
        enable = 1;
        tick();
        check("guard_busreq", 32'(bus_req), 1);
        seen_ack = 0; w0 = wr_cnt;
        dev_on = 0;
        wait_done("guard_drop");
        check("guard_drop_wc", 32'(word_count), 0);
        tick();
        check("guard_drop_ack", 32'(seen_ack), 0);
        check("guard_drop_writes", 32'(wr_cnt - w0), 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_io_channel.md
# dma_io_channel

DMA receive channel that services a buffered I/O device's interrupt-driven burst: it sees the device request line, wins the system bus from the CPU, acknowledges the device, captures each word the device places on the data bus, and writes the words to consecutive main-memory addresses. It sits between an I/O device's GPIO/Ack/databus pins and the memory write port, as the initiator/reader counterpart of the device's responder/streaming side.

## Interface
- ADDR_W, 13, memory word-address width (8192-word memory)
- CNT_W, 6, width of word counter and `max_words`
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  channel armed; sampled in IDLE only
- start_addr  in  ADDR_W  destination base address, latched on leaving IDLE
- max_words  in  CNT_W  terminal word count, latched on leaving IDLE
- gpio_req  in  1  device request (device GPIO line), level
- io_data  in  32  word driven by device on the data bus
- ack  out  1  acknowledge to device (device Ack input)
- io_write  out  1  bus direction to device; 0 = device drives bus
- bus_req  out  1  bus request to CPU
- bus_grant  in  1  bus grant from CPU
- mem_we  out  1  memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  memory write address
- mem_wdata  out  32  memory write data
- word_count  out  CNT_W  words written in current/last burst
- done  out  1  one-cycle pulse at burst end
- abort  out  1  sticky: last burst ended by grant loss; cleared on next burst start

## Operation
- States: IDLE, BUSREQ, ACK, XFER, DONE.
- IDLE: ack=0, bus_req=0, io_write=1. If enable && gpio_req && max_words!=0: latch start_addr/max_words, clear word_count and abort, go BUSREQ. max_words==0 keeps channel in IDLE.
- BUSREQ: bus_req=1. On bus_grant=1 go ACK. gpio_req dropping here: go DONE with zero words (no ack ever issued).
- ACK: bus_req=1, ack=1, io_write=0; one settle cycle for device to drive first word; go XFER unconditionally.
- XFER: bus_req=1, ack=1, io_write=0. Each cycle with gpio_req=1 and word_count<max_words: capture io_data, write it, word_count+1.
  - gpio_req=0 (device empty): no capture, go DONE.
  - word_count reaches max_words on this capture: go DONE (device may still request; re-arms from IDLE).
  - bus_grant=0: no capture, set abort, go DONE.
  - gpio_req=0 and bus_grant=0 together: abort set (grant loss wins).
- DONE: ack=0, bus_req=0, io_write=1, done=1 for exactly this cycle; go IDLE.
- Address: mem_addr = latched start_addr + word_count, modulo 2^ADDR_W (wraps 8191 -> 0).
- word_count holds after DONE until next burst start.

## Timing
- Reset (async assert, sync release): state IDLE, ack=0, io_write=1, bus_req=0, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, done=0, abort=0. Reset mid-burst drops ack/bus_req immediately; any unwritten data lost.
- All outputs registered.
- Request to bus_req: 1 cycle after enable&&gpio_req sampled.
- bus_grant sampled high -> ack high next cycle; first capture 2 cycles after ack rises (ACK state then first XFER edge).
- Capture on rising edge k -> mem_we/mem_addr/mem_wdata valid cycle k+1, for one cycle; back-to-back writes every cycle.
- Final write cycle coincides with DONE cycle (done and last mem_we high together).
- Throughput 1 word/cycle; no backpressure from memory.

## Test plan
- Basic burst: start_addr=0x100, max_words=32, device streams 5 words 0xA0..0xA4 then drops gpio_req -> writes 0x100..0x104 with those data, word_count=5, one done pulse, abort=0.
- Terminal count: max_words=3, device holds gpio_req with 8 words -> exactly 3 writes, ack drops after third capture, done pulse, channel returns to IDLE and re-requests next cycle.
- Grant delay and loss: bus_grant withheld 4 cycles, then dropped after 2 captures -> ack only after grant, 2 writes, abort=1, done pulse; next burst clears abort.
- Address wrap: start_addr=8190, 4 words -> addresses 8190, 8191, 0, 1.
- Reset mid-XFER: rst_n low after 2 captures -> ack, bus_req, mem_we drop asynchronously, word_count=0, state IDLE.
- Guards: max_words=0 or enable=0 with gpio_req=1 -> bus_req never asserts; gpio_req drop in BUSREQ -> done pulse, zero writes, ack never asserted.
